// File: rtl/rename_regfile_if.sv
// Bundle between the issue/ROB side (master) and the rename register file (slave).
// rdy is a global enable rather than a handshake: when low, flush/issue/commit are ignored.
interface rename_regfile_if #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2
);
  localparam int AW = $clog2(NUM_REGS);

  logic                    rdy;
  logic                    flush;
  logic                    iss_en;
  logic [AW-1:0]           iss_rd;
  logic [TAG_W-1:0]        iss_tag;
  logic                    cmt_en;
  logic [AW-1:0]           cmt_rd;
  logic [TAG_W-1:0]        cmt_tag;
  logic [XLEN-1:0]         cmt_val;
  logic [NUM_RD*AW-1:0]    rd_addr;
  logic [NUM_RD*XLEN-1:0]  rd_val;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic [NUM_RD-1:0]       rd_busy;
  logic [AW:0]             busy_cnt;

  modport master (
    output rdy, flush, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_val, rd_addr,
    input  rd_val, rd_tag, rd_busy, busy_cnt
  );

  modport slave (
    input  rdy, flush, iss_en, iss_rd, iss_tag, cmt_en, cmt_rd, cmt_tag, cmt_val, rd_addr,
    output rd_val, rd_tag, rd_busy, busy_cnt
  );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, flush and a busy counter.
// Define RENAME_RF_BYPASS_EN to forward a clearing commit straight to the read ports.
module rename_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int TAG_W    = 4,
  parameter int NUM_RD   = 2
) (
  input logic clk,
  input logic rst_n,
  rename_regfile_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0]     val_q [NUM_REGS];
  logic [TAG_W-1:0]    tag_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic [AW:0]         busy_cnt_q;

  logic cmt_wr, cmt_hit, iss_wr, cnt_inc, cnt_dec;

  always_comb begin
    cmt_wr  = bus.rdy && bus.cmt_en && (bus.cmt_rd != '0);
    cmt_hit = cmt_wr && busy_q[bus.cmt_rd] && (tag_q[bus.cmt_rd] == bus.cmt_tag);
    iss_wr  = bus.rdy && bus.iss_en && (bus.iss_rd != '0) && !bus.flush;
    cnt_inc = iss_wr && !busy_q[bus.iss_rd];
    // A clear cancelled by a same-register re-issue leaves the count alone.
    cnt_dec = cmt_hit && !(iss_wr && (bus.iss_rd == bus.cmt_rd));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        val_q[r] <= '0;
        tag_q[r] <= '0;
      end
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      if (cmt_wr) val_q[bus.cmt_rd] <= bus.cmt_val;
      if (bus.rdy) begin
        if (bus.flush) begin
          busy_q     <= '0;
          busy_cnt_q <= '0;
        end else begin
          if (cmt_hit) busy_q[bus.cmt_rd] <= 1'b0;
          // Issue comes second so it overrides a same-register clear.
          if (iss_wr) begin
            tag_q[bus.iss_rd]  <= bus.iss_tag;
            busy_q[bus.iss_rd] <= 1'b1;
          end
          case ({cnt_inc, cnt_dec})
            2'b10:   busy_cnt_q <= busy_cnt_q + 1'b1;
            2'b01:   busy_cnt_q <= busy_cnt_q - 1'b1;
            default: busy_cnt_q <= busy_cnt_q;
          endcase
        end
      end
    end
  end

  logic [AW-1:0]           addr [NUM_RD];
  logic [NUM_RD*XLEN-1:0]  rd_val;
  logic [NUM_RD*TAG_W-1:0] rd_tag;
  logic [NUM_RD-1:0]       rd_busy;

  always_comb begin
    rd_val  = '0;
    rd_tag  = '0;
    rd_busy = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      addr[p] = bus.rd_addr[p*AW +: AW];
      if (addr[p] != '0) begin
        rd_val[p*XLEN +: XLEN]   = val_q[addr[p]];
        rd_tag[p*TAG_W +: TAG_W] = tag_q[addr[p]];
        rd_busy[p]               = busy_q[addr[p]];
`ifdef RENAME_RF_BYPASS_EN
        if (cmt_hit && (addr[p] == bus.cmt_rd)) begin
          rd_val[p*XLEN +: XLEN] = bus.cmt_val;
          rd_busy[p]             = 1'b0;
        end
`endif
      end
    end
  end

  assign bus.rd_val   = rd_val;
  assign bus.rd_tag   = rd_tag;
  assign bus.rd_busy  = rd_busy;
  assign bus.busy_cnt = busy_cnt_q;
endmodule

// File: tb/tb_rename_regfile.sv
// Randomised and directed bench for rename_regfile against an array-based reference model.
module tb_rename_regfile;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 4;
  localparam int NUM_RD   = 2;
  localparam int AW       = $clog2(NUM_REGS);
  localparam int W        = AW + 1 + NUM_RD * (1 + TAG_W + XLEN);

  logic clk;
  logic rst_n;

  rename_regfile_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) bus ();

  rename_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_RD(NUM_RD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got running required finished");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [XLEN-1:0]  m_val  [NUM_REGS];
  logic [TAG_W-1:0] m_tag  [NUM_REGS];
  bit               m_busy [NUM_REGS];

  logic [W-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  task automatic model_reset();
    for (int r = 0; r < NUM_REGS; r++) begin
      m_val[r]  = '0;
      m_tag[r]  = '0;
      m_busy[r] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] expect_now();
    logic [NUM_RD*XLEN-1:0]  ev;
    logic [NUM_RD*TAG_W-1:0] et;
    logic [NUM_RD-1:0]       eb;
    logic [AW:0]             ec;
    logic [AW-1:0]           a;
    int cnt;
    ev = '0; et = '0; eb = '0; cnt = 0;
    for (int r = 0; r < NUM_REGS; r++) cnt += int'(m_busy[r]);
    ec = cnt[AW:0];
    for (int p = 0; p < NUM_RD; p++) begin
      a = bus.rd_addr[p*AW +: AW];
      if (a != 0) begin
        ev[p*XLEN +: XLEN]   = m_val[a];
        et[p*TAG_W +: TAG_W] = m_tag[a];
        eb[p]                = m_busy[a];
`ifdef RENAME_RF_BYPASS_EN
        if (bus.rdy && bus.cmt_en && bus.cmt_rd != 0 && a == bus.cmt_rd &&
            m_busy[a] && m_tag[a] == bus.cmt_tag) begin
          ev[p*XLEN +: XLEN] = bus.cmt_val;
          eb[p]              = 1'b0;
        end
`endif
      end
    end
    return {ec, eb, et, ev};
  endfunction

  task automatic model_update();
    bit hit;
    if (!bus.rdy) return;
    hit = bus.cmt_en && bus.cmt_rd != 0 && m_busy[bus.cmt_rd] && m_tag[bus.cmt_rd] == bus.cmt_tag;
    if (bus.cmt_en && bus.cmt_rd != 0) m_val[bus.cmt_rd] = bus.cmt_val;
    if (bus.flush) begin
      for (int r = 0; r < NUM_REGS; r++) m_busy[r] = 1'b0;
    end else begin
      if (hit) m_busy[bus.cmt_rd] = 1'b0;
      if (bus.iss_en && bus.iss_rd != 0) begin
        m_tag[bus.iss_rd]  = bus.iss_tag;
        m_busy[bus.iss_rd] = 1'b1;
      end
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [W-1:0] exp_v, act_v;
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      act_v = {bus.busy_cnt, bus.rd_busy, bus.rd_tag, bus.rd_val};
      vectors++;
      if (act_v !== exp_v) begin
        miscompares++;
        $display("FAIL rd_check t=%0t got cnt/busy/tag/val=%h required %h", $time, act_v, exp_v);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.rdy = 1'b1; bus.flush = 1'b0;
    bus.iss_en = 1'b0; bus.iss_rd = '0; bus.iss_tag = '0;
    bus.cmt_en = 1'b0; bus.cmt_rd = '0; bus.cmt_tag = '0; bus.cmt_val = '0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    bus.rd_addr = {a1, a0};
  endtask

  task automatic iss(input logic [AW-1:0] rd, input logic [TAG_W-1:0] tag);
    bus.iss_en = 1'b1; bus.iss_rd = rd; bus.iss_tag = tag;
  endtask

  task automatic cmt(input logic [AW-1:0] rd, input logic [TAG_W-1:0] tag, input logic [XLEN-1:0] v);
    bus.cmt_en = 1'b1; bus.cmt_rd = rd; bus.cmt_tag = tag; bus.cmt_val = v;
  endtask

  // One cycle: expected read response for the current inputs, then the edge.
  task automatic step();
    exp_q.push_back(expect_now());
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic async_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(expect_now());
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5, 0);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // rename then matching commit
    set_rd(3, 0);
    iss(3, 7); step();
    idle(); cmt(3, 7, 32'hDEAD_BEEF); step();
    idle(); step();

    // stale-tag commit after re-rename
    iss(3, 7); step();
    iss(3, 9); step();
    idle(); cmt(3, 7, 32'h11); step();
    idle(); step();

    // same-cycle issue and matching commit; x0 writes
    set_rd(4, 3);
    iss(4, 2); step();
    iss(4, 2); cmt(4, 2, 32'h55); step();
    idle(); step();
    set_rd(0, 4);
    iss(0, 5); cmt(0, 5, 32'hFF); step();
    idle(); step();

    // flush with concurrent commit and issue; rdy low freezes state
    set_rd(1, 2);
    iss(1, 1); step();
    iss(2, 2); step();
    iss(6, 6); step();
    idle(); bus.flush = 1'b1; cmt(1, 1, 32'hA); iss(7, 4); step();
    idle(); set_rd(1, 7); step();
    set_rd(6, 5); step();
    bus.rdy = 1'b0; iss(5, 3); cmt(6, 6, 32'h77); step();
    idle(); step();

    // commit visibility while reading the register
    set_rd(8, 0);
    iss(8, 3); step();
    idle(); cmt(8, 3, 32'h1234); step();
    idle(); step();

    // asynchronous reset mid-run
    iss(9, 1); set_rd(9, 8); step();
    idle(); step();
    async_reset();
    step();

    // randomised traffic over a small register window to force collisions
    for (int i = 0; i < 600; i++) begin
      bus.rdy     = ($urandom_range(0, 7) != 0);
      bus.flush   = ($urandom_range(0, 19) == 0);
      bus.iss_en  = $urandom_range(0, 1);
      bus.iss_rd  = AW'($urandom_range(0, 7));
      bus.iss_tag = TAG_W'($urandom);
      bus.cmt_en  = $urandom_range(0, 1);
      bus.cmt_rd  = ($urandom_range(0, 3) == 0) ? bus.iss_rd : AW'($urandom_range(0, 7));
      bus.cmt_tag = ($urandom_range(0, 1) == 0) ? m_tag[bus.cmt_rd] : TAG_W'($urandom);
      bus.cmt_val = $urandom;
      for (int p = 0; p < NUM_RD; p++)
        bus.rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? bus.cmt_rd : AW'($urandom_range(0, 7));
      if (i == 300) async_reset();
      step();
    end

    idle();
    step();
    @(posedge clk);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expectations required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with per-register rename tags for the out-of-order core.
- Generalises the fixed 32x32, two-read-port register/tag file to configurable data width, register count, tag width and read-port count.
- Adds three things the earlier block lacks: a global flush, a registered busy-register counter, and optional commit-to-read bypass.
- Sits between the decoder/issue stage (renames rd, reads rs1/rs2) and the ROB commit stage.

Parameters:
- XLEN, 32, data width of each register
- NUM_REGS, 32, number of architectural registers; power of two, >= 2; register 0 hardwired to zero
- TAG_W, 4, width of a rename tag (ROB index)
- NUM_RD, 2, number of read ports
- AW (localparam), $clog2(NUM_REGS), register address width

Ports:
- clk_in  input  1  system clock, rising edge
- rst_n_in  input  1  asynchronous reset, active-low
- rdy_in  input  1  ready; when low, all state holds (flush, issue and commit ignored)
- flush_in  input  1  mispredict flush; clears all busy flags
- iss_en_in  input  1  issue stage renames a destination this cycle
- iss_rd_in  input  AW  destination register being renamed
- iss_tag_in  input  TAG_W  tag assigned to that destination
- cmt_en_in  input  1  ROB commits a register write this cycle
- cmt_rd_in  input  AW  committed destination register
- cmt_tag_in  input  TAG_W  tag of the committing entry
- cmt_val_in  input  XLEN  committed value
- rd_addr_in  input  NUM_RD*AW  read addresses; port i at bits [i*AW +: AW]
- rd_val_out  output  NUM_RD*XLEN  register values
- rd_tag_out  output  NUM_RD*TAG_W  current tag of each addressed register
- rd_busy_out  output  NUM_RD  1 = value pending on rd_tag_out
- busy_cnt_out  output  AW+1  number of registers currently busy

Behaviour:
- State:
  - val[NUM_REGS] (XLEN bits each)
  - tag[NUM_REGS] (TAG_W bits each)
  - busy[NUM_REGS] (1 bit each)
  - busy_cnt (AW+1 bits)
- Reset (rst_n_in low, asynchronous, takes effect immediately regardless of clock or rdy_in):
  - all val, tag, busy and busy_cnt = 0.
  - Outputs are therefore rd_val_out = 0, rd_tag_out = 0, rd_busy_out = 0, busy_cnt_out = 0.
  - Reset asserted mid-operation discards any pending issue/commit.
- Reads: combinational from current state; zero latency. Address 0 always reads val = 0, tag = 0, busy = 0.
- Updates happen on the rising edge when rdy_in = 1; rdy_in = 0 freezes all state.
- Commit (cmt_en_in = 1, cmt_rd_in != 0):
  - val[cmt_rd_in] <= cmt_val_in, unconditionally.
  - busy[cmt_rd_in] <= 0 only if busy is set and tag[cmt_rd_in] == cmt_tag_in. A stale tag updates the value and leaves busy/tag unchanged.
- Issue (iss_en_in = 1, iss_rd_in != 0, flush_in = 0): tag[iss_rd_in] <= iss_tag_in; busy[iss_rd_in] <= 1.
- Issue and commit to the same register in the same cycle:
  - value is written from the commit;
  - issue wins for tag/busy (busy = 1, tag = iss_tag_in), whether or not the commit tag matched.
- Flush (flush_in = 1):
  - all busy <= 0 and busy_cnt <= 0; issue is ignored; tags are left unchanged.
  - A commit in the same cycle still writes val.
- Writes to register 0 by issue or commit are discarded.
- busy_cnt is a registered counter, not a popcount:
  - +1 when issue sets a previously non-busy register;
  - -1 when a matching commit clears a register that is not re-issued this cycle;
  - same-register issue plus matching commit gives net 0;
  - issue to an already-busy register gives net 0;
  - an issue and a clearing commit on different registers give net 0.
- busy_cnt must never wrap; the maximum value is NUM_REGS-1, since x0 is never busy.

Optional Feature:
- Macro: RENAME_RF_BYPASS_EN.
- Defined: a read port is bypassed when all of the following hold in the same cycle:
  - rdy_in = 1, cmt_en_in = 1, cmt_rd_in != 0;
  - the port's address equals cmt_rd_in;
  - the register is busy and tag[cmt_rd_in] == cmt_tag_in.
- A bypassed port returns rd_val_out = cmt_val_in and rd_busy_out = 0 combinationally.
- The bypass is based on pre-edge state: a same-cycle issue to that register does not affect the read.
- Not defined: reads reflect only registered state; a commit becomes visible on the following cycle.

Test Plan:
- Reset release, NUM_RD = 2, read x5/x0 -> val 0, tag 0, busy 0, busy_cnt 0; async assertion mid-run clears all within the same cycle, no clock edge needed.
- Issue x3 tag 7, next cycle commit x3 tag 7 val 0xDEADBEEF -> after issue: busy 1, tag 7, busy_cnt 1; after commit: val 0xDEADBEEF, busy 0, busy_cnt 0.
- Issue x3 tag 7, then issue x3 tag 9, then commit x3 tag 7 val 0x11 -> val 0x11, busy 1, tag 9, busy_cnt 1.
- Same-cycle issue x4 tag 2 and matching commit x4 val 0x55 -> val 0x55, busy 1, tag 2, busy_cnt unchanged; issue/commit to x0 -> no change.
- Busy x1, x2, x6, then flush_in with commit x1 val 0xA and issue x7 -> all busy 0, busy_cnt 0, x1 val 0xA, x7 not busy; rdy_in = 0 during issue -> nothing changes.
- With RENAME_RF_BYPASS_EN, x8 busy tag 3, commit x8 tag 3 val 0x1234 while reading x8 -> same-cycle rd_val 0x1234, busy 0; without the macro -> old value and busy 1, new value on the next cycle.
